// File: rtl/seg_scan_4digit.sv
// rtl/seg_scan_4digit.sv - multiplexed 4-digit BCD seven-segment scanner with frame-synchronous update
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zeros of the upper three digits).
module seg_scan_4digit #(
    parameter int unsigned DIV_CNT   = 100000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd_in,
    input  logic        bcd_valid,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int unsigned     CNT_W     = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    // Timing state: prescaler and slot index (0 = units ... 3 = thousands)
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;

    // Value path: shadow capture, pending flag, frame-stable display value
    logic [15:0]      shadow_q, shadow_d;
    logic [15:0]      disp_q, disp_d;
    logic             pending_q, pending_d;

    // Registered pin drivers
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             fd_q, fd_d;

    logic             slot_wrap;
    logic             frame_wrap;
    logic             ghost_blank;
    logic             lz_blank;
    logic [3:0]       cur_digit;

    // BCD to active-low gfedcba; anything above 9 shows a dash
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    // Slot and frame boundary detection
    always_comb begin
        slot_wrap  = (cnt_q == CNT_LAST);
        frame_wrap = slot_wrap && (idx_q == 2'd3);
    end

    // Prescaler and slot index advance
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (slot_wrap) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Capture into the shadow at any time; promote to the display only at a frame boundary
    always_comb begin
        shadow_d  = shadow_q;
        disp_d    = disp_q;
        pending_d = pending_q;
        if (bcd_valid) begin
            shadow_d = bcd_in;
        end
        if (frame_wrap) begin
            // A strobe landing on the boundary edge is the newest value, so it bypasses the shadow
            if (bcd_valid) begin
                disp_d = bcd_in;
            end else if (pending_q) begin
                disp_d = shadow_q;
            end
            pending_d = 1'b0;
        end else if (bcd_valid) begin
            pending_d = 1'b1;
        end
    end

    // Select the digit belonging to the active slot
    always_comb begin
        cur_digit = disp_q[3:0];
        case (idx_q)
            2'd0:    cur_digit = disp_q[3:0];
            2'd1:    cur_digit = disp_q[7:4];
            2'd2:    cur_digit = disp_q[11:8];
            default: cur_digit = disp_q[15:12];
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every more-significant digit are zero; units always shows
    always_comb begin
        lz_blank = 1'b0;
        case (idx_q)
            2'd3:    lz_blank = (disp_q[15:12] == 4'd0);
            2'd2:    lz_blank = (disp_q[15:8] == 8'd0);
            2'd1:    lz_blank = (disp_q[15:4] == 12'd0);
            default: lz_blank = 1'b0;
        endcase
    end
`else
    // Every digit is shown, leading zeros included
    always_comb begin
        lz_blank = 1'b0;
    end
`endif

    // Next values for the pin registers, one clock behind the scan state
    always_comb begin
        ghost_blank = (cnt_q < CNT_BLANK);
        an_d        = 4'b1111;
        seg_d       = SEG_OFF;
        fd_d        = frame_wrap;
        if (!ghost_blank) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = lz_blank ? SEG_OFF : seg_decode(cur_digit);
        end
    end

    // All state and pin registers, synchronous reset drops any pending capture
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            shadow_q  <= 16'h0000;
            disp_q    <= 16'h0000;
            pending_q <= 1'b0;
            an_q      <= 4'b1111;
            seg_q     <= SEG_OFF;
            fd_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            fd_q      <= fd_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = fd_q;
    assign dp         = 1'b1;

endmodule

// File: tb/tb_seg_scan_4digit.sv
// tb/tb_seg_scan_4digit.sv - directed scoreboard bench for seg_scan_4digit (DIV_CNT=8, BLANK_CYC=2)
module tb_seg_scan_4digit;

    localparam int DIV   = 8;
    localparam int BLK   = 2;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bcd_in = 16'h0000;
    logic        bcd_valid = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    exp_t sb_q[$];

    seg_scan_4digit #(
        .DIV_CNT  (DIV),
        .BLANK_CYC(BLK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bcd_in    (bcd_in),
        .bcd_valid (bcd_valid),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] seg_ref(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic exp_t slot_ref(input logic [15:0] v, input int k);
        exp_t e;
        logic [3:0] d;
        d = v[4*k +: 4];
        e.an = 4'b1111;
        e.an[k] = 1'b0;
        e.seg = seg_ref(d);
`ifdef LEADING_ZERO_BLANK_EN
        if ((k == 3 && v[15:12] == 4'd0) || (k == 2 && v[15:8] == 8'd0) ||
            (k == 1 && v[15:4] == 12'd0))
            e.seg = 7'b1111111;
`endif
        return e;
    endfunction

    task automatic push_frame(input logic [15:0] v);
        for (int k = 0; k < 4; k++) sb_q.push_back(slot_ref(v, k));
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called on the negedge where frame_done is high; walks one full frame and ends on the next frame_done
    task automatic scan_frame(input string tag, input int s1_t, input logic [15:0] s1_v,
                              input int s2_t, input logic [15:0] s2_v);
        exp_t e;
        for (int t = 1; t <= FRAME; t++) begin
            @(negedge clk);
            bcd_valid = 1'b0;
            if (t == s1_t) begin
                bcd_in = s1_v;
                bcd_valid = 1'b1;
            end
            if (t == s2_t) begin
                bcd_in = s2_v;
                bcd_valid = 1'b1;
            end
            if ((t % DIV) == 1) check({tag, "_ghost_an"}, 16'(an), 16'hF);
            if ((t % DIV) == 5) begin
                if (sb_q.size() == 0) begin
                    check({tag, "_sb_empty"}, 16'(sb_q.size()), 16'd1);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("%s_slot%0d_an", tag, t / DIV), 16'(an), 16'(e.an));
                    check($sformatf("%s_slot%0d_seg", tag, t / DIV), 16'(seg), 16'(e.seg));
                end
            end
            if (t == FRAME / 2) check({tag, "_fd_low"}, 16'(frame_done), 16'd0);
            if (t == FRAME) check({tag, "_fd_high"}, 16'(frame_done), 16'd1);
        end
        bcd_valid = 1'b0;
    endtask

    // Counts negedges after reset release until frame_done, bounded
    task automatic wait_first_fd(input string tag);
        int n;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (n == 1 || n == 2) check({tag, "_post_rst_blank"}, 16'(an), 16'hF);
            if (n == 3) begin
                check({tag, "_units_an"}, 16'(an), 16'hE);
                check({tag, "_units_seg"}, 16'(seg), 16'b1000000);
            end
            if (frame_done) break;
        end
        check({tag, "_first_fd_latency"}, 16'(n), 16'(FRAME));
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_an", 16'(an), 16'hF);
        check("rst_seg", 16'(seg), 16'h7F);
        check("rst_fd", 16'(frame_done), 16'd0);
        check("rst_dp", 16'(dp), 16'd1);
        rst = 1'b0;
        wait_first_fd("boot");

        // Mid-frame capture holds off until the boundary
        push_frame(16'h0000);
        scan_frame("mid_1234", 12, 16'h1234, 0, 16'h0);
        push_frame(16'h1234);
        scan_frame("show_1234", 0, 16'h0, 0, 16'h0);

        // Leading-zero candidate
        push_frame(16'h1234);
        scan_frame("hold_1234", 20, 16'h0009, 0, 16'h0);
        push_frame(16'h0009);
        scan_frame("show_0009", 0, 16'h0, 0, 16'h0);

        // Dash digits
        push_frame(16'h0009);
        scan_frame("hold_0009", 3, 16'hA0F5, 0, 16'h0);
        push_frame(16'hA0F5);
        scan_frame("show_A0F5", 0, 16'h0, 0, 16'h0);

        // Strobe exactly on the frame-boundary edge
        push_frame(16'hA0F5);
        scan_frame("edge_0042", FRAME - 1, 16'h0042, 0, 16'h0);
        push_frame(16'h0042);
        scan_frame("show_0042", 6, 16'h1111, 14, 16'h2222);
        push_frame(16'h2222);
        scan_frame("show_2222", 0, 16'h0, 0, 16'h0);

        // Reset in the middle of a pending capture
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            bcd_valid = 1'b0;
            if (t == 3) begin
                bcd_in = 16'h5555;
                bcd_valid = 1'b1;
            end
            if (t == 10) rst = 1'b1;
            if (t == 12) begin
                check("midrst_an", 16'(an), 16'hF);
                check("midrst_seg", 16'(seg), 16'h7F);
                check("midrst_fd", 16'(frame_done), 16'd0);
                rst = 1'b0;
            end
        end
        wait_first_fd("after_rst");
        push_frame(16'h0000);
        scan_frame("discard_5555", 0, 16'h0, 0, 16'h0);

        check("sb_drained", 16'(sb_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
